flex_down_timer: RTL and testbench
==================================

Name: flex_down_timer

Overview:
Loadable, prescaled down-counter timer for protocol timing: bit-period timeouts, inter-packet gaps and EOP wait windows.
- Counterpart to the up-counting flex counters: software or an FSM loads a duration, the block counts it down and reports one expiry event.
- Sits beside the TX/RX control FSMs and is driven directly by them.
- Supports pause (enable low), abort (clear) and optional auto-reload for periodic ticks.

Parameters:
NUM_CNT_BITS, 4, width of the main down-counter and of load_val.
PRESCALE_BITS, 4, width of the prescaler counter and of prescale_val.

Ports:
clk  in  1  system clock, rising edge.
n_rst  in  1  reset, asynchronous, active-low.
clear  in  1  synchronous abort: returns the block to idle with count 0.
load  in  1  synchronous start: captures load_val and begins the countdown.
load_val  in  NUM_CNT_BITS  duration, in prescaled ticks.
prescale_val  in  PRESCALE_BITS  a tick occurs every prescale_val+1 enabled cycles.
count_enable  in  1  while low, the prescaler and counter hold.
auto_reload  in  1  when high at expiry, the stored duration is reloaded and counting restarts.
count_out  out  NUM_CNT_BITS  current remaining count, registered.
busy  out  1  high while in the RUN state.
expire_flag  out  1  single-cycle pulse, high in the EXPIRE state.
zero_flag  out  1  high when count_out == 0.

Behaviour:
- Reset (n_rst low, asynchronous): state IDLE, count_out 0, prescaler 0, reload register 0, busy 0, expire_flag 0, zero_flag 1.
- All outputs are registered or decoded from registered state. No combinational path from inputs to outputs.
- States: IDLE, RUN, EXPIRE. busy = (state==RUN); expire_flag = (state==EXPIRE).
- Priority per cycle: clear > load > tick > hold.
- clear: count 0, prescaler 0, reload register 0, next state IDLE, from any state. clear and load together: clear wins.
- load in any state (including RUN and EXPIRE):
  - count <= load_val, reload register <= load_val, prescaler <= 0.
  - Next state RUN if load_val != 0, else EXPIRE (immediate expiry pulse next cycle, count 0).
- Tick: state==RUN && count_enable && prescaler >= prescale_val.
  - On a tick the prescaler wraps to 0.
  - Otherwise, while RUN && count_enable, the prescaler increments.
  - The >= comparison makes a live decrease of prescale_val safe.
- In RUN on a tick: count decrements. If count==1, count becomes 0 and the next state is EXPIRE.
- EXPIRE lasts exactly one cycle, independent of count_enable.
  - If auto_reload && reload register != 0: count <= reload register, prescaler 0, next state RUN.
  - Otherwise: next state IDLE, count stays 0.
- IDLE holds all values; count_enable has no effect there.
- Latency: from the load edge, expire_flag rises after load_val*(prescale_val+1) enabled cycles. count_out shows load_val on the cycle after load is sampled.
- Pausing: count_enable low in RUN freezes both the count and the prescaler. There is no loss of partial prescale progress.
- Auto-reload period is load_val*(prescale_val+1)+1 cycles, including the one EXPIRE cycle.
- No wrap-around below 0: a decrement from 0 is unreachable by construction. An assertion must check this.

Decomposition:
- Package timer_pkg:
  - typedef enum logic [1:0] timer_state_t {IDLE, RUN, EXPIRE}.
  - localparam for the default widths.
- Sub-module timer_prescaler:
  - Ports: clk, n_rst, clr, en, prescale_val, tick.
  - Contains the PRESCALE_BITS counter with the >= wrap rule.
  - clr is driven by clear | load | (state==EXPIRE).
- Top module: FSM, down-counter, reload register, output decode.

Test Plan:
- Reset with all inputs at 0 -> count_out 0, zero_flag 1, busy 0, expire_flag 0. Release reset, idle 5 cycles -> no change.
- prescale_val 0, load_val 3, count_enable 1, auto_reload 0 -> count_out 3,2,1,0 on consecutive cycles. expire_flag high exactly on the cycle count reaches 0, then IDLE; busy high for 3 cycles.
- prescale_val 2, load_val 2 -> count steps every 3 cycles. expire_flag rises 6 cycles after load. Drop count_enable for 4 cycles mid-run -> expiry delayed by exactly 4 cycles.
- auto_reload 1, prescale_val 0, load_val 2 -> expire_flag pulses every 3 cycles, count_out sequence 2,1,0,2,1,0…. Deassert auto_reload -> the next expiry goes to IDLE.
- Simultaneous events:
  - load with load_val 5 during EXPIRE -> count 5, RUN next cycle.
  - clear and load together during RUN -> IDLE, count 0.
  - load_val 0 -> single expire_flag pulse next cycle.
- Assert n_rst mid-RUN with count 4 -> outputs return to reset values immediately (asynchronous). After release, the block stays IDLE until the next load.

Source files
------------

// File: rtl/timer_pkg.sv
// timer_pkg: shared state type and default widths for flex_down_timer
package timer_pkg;
  typedef enum logic [1:0] {IDLE, RUN, EXPIRE} timer_state_t;
  localparam int DEF_CNT_BITS = 4;
  localparam int DEF_PRE_BITS = 4;
endpackage

// File: rtl/timer_prescaler.sv
// timer_prescaler: divides enabled cycles into ticks every prescale_val+1 cycles
module timer_prescaler
  import timer_pkg::*;
#(
  parameter int PRESCALE_BITS = DEF_PRE_BITS
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic                     clr,
  input  logic                     en,
  input  logic [PRESCALE_BITS-1:0] prescale_val,
  output logic                     tick
);
  logic [PRESCALE_BITS-1:0] pre_q, pre_d;
  // >= rather than == so a live decrease of prescale_val cannot strand the phase above it
  assign tick = en && (pre_q >= prescale_val);
  // restart clears the phase, a tick wraps it, paused cycles keep partial progress
  always_comb pre_d = (clr || tick) ? '0 : en ? pre_q + PRESCALE_BITS'(1) : pre_q;
  // phase register
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) pre_q <= '0;
    else        pre_q <= pre_d;
endmodule

// File: rtl/flex_down_timer.sv
// flex_down_timer: loadable prescaled down-counter with one-cycle expiry pulse and optional auto-reload
module flex_down_timer
  import timer_pkg::*;
#(
  parameter int NUM_CNT_BITS  = DEF_CNT_BITS,
  parameter int PRESCALE_BITS = DEF_PRE_BITS
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic                     clear,
  input  logic                     load,
  input  logic [NUM_CNT_BITS-1:0]  load_val,
  input  logic [PRESCALE_BITS-1:0] prescale_val,
  input  logic                     count_enable,
  input  logic                     auto_reload,
  output logic [NUM_CNT_BITS-1:0]  count_out,
  output logic                     busy,
  output logic                     expire_flag,
  output logic                     zero_flag
);
  timer_state_t              state_q, state_d;
  logic [NUM_CNT_BITS-1:0]   cnt_q, cnt_d, rld_q, rld_d;
  logic                      tick, reload_go;
  timer_prescaler #(.PRESCALE_BITS(PRESCALE_BITS)) u_pre (
    .clk          (clk),
    .n_rst        (n_rst),
    .clr          (clear || load || state_q == EXPIRE),
    .en           (state_q == RUN && count_enable),
    .prescale_val (prescale_val),
    .tick         (tick)
  );
  assign reload_go = state_q == EXPIRE && auto_reload && rld_q != '0;
  // next state with priority clear > load > tick > hold; EXPIRE never lingers
  always_comb begin
    state_d = clear ? IDLE
            : load ? (load_val != '0 ? RUN : EXPIRE)
            : (tick && cnt_q == NUM_CNT_BITS'(1)) ? EXPIRE
            : state_q == EXPIRE ? (reload_go ? RUN : IDLE)
            : state_q;
    cnt_d   = clear ? '0
            : load ? load_val
            : tick ? cnt_q - NUM_CNT_BITS'(1)
            : reload_go ? rld_q
            : cnt_q;
    rld_d   = clear ? '0 : load ? load_val : rld_q;
  end
  // state, count and stored duration registers
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rld_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rld_q   <= rld_d;
    end
  assign count_out   = cnt_q;
  assign busy        = state_q == RUN;
  assign expire_flag = state_q == EXPIRE;
  assign zero_flag   = cnt_q == '0;
  // a tick only ever arrives with a nonzero count, so the counter cannot wrap
  a_no_underflow: assert property (@(posedge clk) disable iff (!n_rst) tick |-> cnt_q != '0);
endmodule

// File: tb/tb_flex_down_timer.sv
// tb_flex_down_timer: directed and random checks of flex_down_timer against a behavioural model
module tb_flex_down_timer;
  logic       clk = 1'b0, n_rst = 1'b0, clear = 1'b0, load = 1'b0;
  logic       count_enable = 1'b0, auto_reload = 1'b0;
  logic [3:0] load_val = '0, prescale_val = '0;
  logic [3:0] count_out;
  logic       busy, expire_flag, zero_flag;
  int n_chk = 0, n_fail = 0;
  int m_st = 0, m_cnt = 0, m_ph = 0, m_rld = 0;
  int c, c0, busy_n, e_at;

  always #5 clk = ~clk;

  flex_down_timer dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .clear        (clear),
    .load         (load),
    .load_val     (load_val),
    .prescale_val (prescale_val),
    .count_enable (count_enable),
    .auto_reload  (auto_reload),
    .count_out    (count_out),
    .busy         (busy),
    .expire_flag  (expire_flag),
    .zero_flag    (zero_flag)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // model: m_st 0=idle 1=running 2=expiry cycle; m_ph counts enabled cycles toward the next tick
  task automatic model_edge();
    if (!n_rst) begin
      m_st = 0; m_cnt = 0; m_ph = 0; m_rld = 0;
    end else if (clear) begin
      m_st = 0; m_cnt = 0; m_ph = 0; m_rld = 0;
    end else if (load) begin
      m_cnt = load_val; m_rld = load_val; m_ph = 0;
      m_st = (load_val != 0) ? 1 : 2;
    end else if (m_st == 1) begin
      if (count_enable) begin
        m_ph++;
        if (m_ph > prescale_val) begin
          m_ph = 0;
          m_cnt--;
          if (m_cnt == 0) m_st = 2;
        end
      end
    end else if (m_st == 2) begin
      m_ph = 0;
      if (auto_reload && m_rld != 0) begin
        m_cnt = m_rld; m_st = 1;
      end else m_st = 0;
    end
  endtask

  task automatic check_model();
    chk("count_out", count_out, m_cnt);
    chk("busy", busy, m_st == 1);
    chk("expire_flag", expire_flag, m_st == 2);
    chk("zero_flag", zero_flag, m_cnt == 0);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_model();
  endtask

  task automatic wait_expire(input string tag, output int cyc);
    cyc = 0;
    for (int i = 1; i <= 200; i++) begin
      step();
      if (expire_flag) begin
        cyc = i;
        return;
      end
    end
    chk({tag, "_timeout"}, 0, 1);
  endtask

  initial begin
    // reset with all inputs low, then idle
    #12;
    chk("rst_count", count_out, 0);
    chk("rst_zero", zero_flag, 1);
    chk("rst_busy", busy, 0);
    chk("rst_expire", expire_flag, 0);
    step();
    n_rst = 1'b1;
    repeat (5) step();
    chk("idle_count", count_out, 0);

    // back-to-back count 3,2,1,0 with no prescale
    prescale_val = 4'd0; load_val = 4'd3; count_enable = 1'b1; auto_reload = 1'b0;
    load = 1'b1; step(); load = 1'b0;
    chk("t1_first", count_out, 3);
    busy_n = busy; e_at = -1;
    for (int i = 1; i <= 7; i++) begin
      step();
      busy_n += busy;
      if (expire_flag && e_at < 0) e_at = i;
    end
    chk("t1_busy_cycles", busy_n, 3);
    chk("t1_expire_lat", e_at, 3);

    // prescale 2: expiry 6 cycles after load
    prescale_val = 4'd2; load_val = 4'd2;
    load = 1'b1; step(); load = 1'b0;
    wait_expire("t2", c);
    chk("t2_latency", c, 6);
    repeat (2) step();
    // same run paused for 4 cycles: expiry 4 cycles later
    load = 1'b1; step(); load = 1'b0;
    repeat (2) step();
    count_enable = 1'b0;
    repeat (4) step();
    count_enable = 1'b1;
    wait_expire("t2p", c);
    chk("t2_pause_latency", c + 6, 10);
    step();

    // auto-reload period of 3 cycles, then drop auto_reload
    prescale_val = 4'd0; load_val = 4'd2; auto_reload = 1'b1;
    load = 1'b1; step(); load = 1'b0;
    wait_expire("t3a", c0);
    chk("t3_first", c0, 2);
    wait_expire("t3b", c);
    chk("t3_period1", c, 3);
    wait_expire("t3c", c);
    chk("t3_period2", c, 3);
    step();
    chk("t3_reloaded", count_out, 2);
    auto_reload = 1'b0;
    wait_expire("t3d", c);
    chk("t3_last", c, 2);
    step();
    chk("t3_idle_busy", busy, 0);

    // load during EXPIRE
    load_val = 4'd1; load = 1'b1; step(); load = 1'b0;
    step();
    chk("t4_in_expire", expire_flag, 1);
    load_val = 4'd5; load = 1'b1; step(); load = 1'b0;
    chk("t4_reload_cnt", count_out, 5);
    chk("t4_reload_busy", busy, 1);
    // clear beats load
    clear = 1'b1; load = 1'b1; load_val = 4'd7; step(); clear = 1'b0; load = 1'b0;
    chk("t4_clear_busy", busy, 0);
    chk("t4_clear_cnt", count_out, 0);
    // zero duration expires at once
    load_val = 4'd0; load = 1'b1; step(); load = 1'b0;
    chk("t4_zero_pulse", expire_flag, 1);
    step();
    chk("t4_zero_after", expire_flag, 0);

    // asynchronous reset in the middle of a run
    prescale_val = 4'd3; load_val = 4'd4;
    load = 1'b1; step(); load = 1'b0;
    chk("t5_running", count_out, 4);
    #2 n_rst = 1'b0;
    #1;
    chk("t5_async_cnt", count_out, 0);
    chk("t5_async_busy", busy, 0);
    chk("t5_async_zero", zero_flag, 1);
    step();
    #2 n_rst = 1'b1;
    repeat (4) step();
    chk("t5_stay_idle", busy, 0);

    // random traffic against the model
    for (int i = 0; i < 800; i++) begin
      clear        = ($urandom % 40) == 0;
      load         = ($urandom % 10) == 0;
      load_val     = 4'($urandom);
      count_enable = ($urandom % 5) != 0;
      auto_reload  = ($urandom % 3) != 0;
      if (($urandom % 25) == 0) prescale_val = 4'($urandom % 4);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
